srlzr_tx_ctrl: RTL and testbench
================================

Name: srlzr_tx_ctrl

Overview:
Frame sequencer for the PISO serializer (srlzr_PISO).
- Accepts parallel words over a valid/ready handshake.
- Drives the serializer's load and shift strobes at a programmed bit rate.
- Muxes start bit, serializer output and stop bit onto the line output.
- Sits between the transmit word source and the transceiver line driver.

Parameters:
DATA_W, 8, word width in bits; must be >= 2.
BAUD_DIV, 4, clock cycles per line bit; must be >= 2.

Ports:
clk  input  1  system clock; all logic on the rising edge
rst  input  1  asynchronous reset, active-high
iDATA  input  DATA_W  word to transmit
iDATA_VALID  input  1  iDATA is valid
oDATA_READY  output  1  controller accepts a word this cycle
oPAR_DATA  output  DATA_W  captured word, to the serializer's parallel input
oLOAD  output  1  serializer load strobe, one cycle wide
oSHIFT  output  1  serializer shift strobe, one cycle wide
iSRL_IN  input  1  serial bit from the serializer (srl_out)
oTX  output  1  line output; idle high
oBUSY  output  1  frame in progress

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous, active-high. All outputs are registered.
- Reset values:
  - oDATA_READY=0, oLOAD=0, oSHIFT=0, oTX=1, oBUSY=0, oPAR_DATA=0.
  - state=IDLE; baud and bit counters = 0.
- Reset asserted mid-frame: the frame is aborted immediately and oTX returns to 1 with no partial stop bit. After release, the first clock edge enters IDLE with oDATA_READY=1.
- States:
  - IDLE, START, DATA, STOP (PARITY added under the optional feature).
- IDLE:
  - oDATA_READY=1, oBUSY=0, oTX=1.
  - A handshake (iDATA_VALID & oDATA_READY at a clock edge) captures iDATA into oPAR_DATA and moves to START.
- START:
  - Lasts BAUD_DIV cycles. oTX=0, oBUSY=1.
  - oLOAD=1 on the first START cycle only.
- DATA:
  - DATA_W bit periods of BAUD_DIV cycles each. oTX follows iSRL_IN (registered).
  - oSHIFT=1 on the last cycle of each data bit period, giving exactly DATA_W shift pulses per frame.
  - The bit counter runs 0..DATA_W-1. After the last bit the state moves to STOP (or PARITY).
- STOP:
  - Lasts BAUD_DIV cycles. oTX=1.
  - oDATA_READY=1 on the last STOP cycle only.
  - A handshake on that cycle is a back-to-back frame: the next cycle enters START directly, with no idle cycle on oTX.
  - With no handshake the state moves to IDLE.
- Frame length: (DATA_W+2)*BAUD_DIV cycles.
- Data latency: the first oTX low appears one cycle after the accepting edge.
- Input rules:
  - oLOAD and oSHIFT are never asserted in the same cycle.
  - iDATA_VALID while oDATA_READY=0 is ignored. Sources must hold iDATA_VALID and iDATA until accepted.
  - iDATA changes after acceptance do not affect the frame in flight.
- Counter rollover: the baud counter wraps BAUD_DIV-1 → 0 on every bit boundary. The bit counter clears on entry to DATA.

Optional Feature:
SRLZR_PARITY_EN
- Defined:
  - PARITY state inserted between DATA and STOP, lasting BAUD_DIV cycles.
  - oTX = even parity (XOR reduction) of the captured oPAR_DATA.
  - Frame length becomes (DATA_W+3)*BAUD_DIV cycles.
- Undefined: no PARITY state, and no parity logic is synthesized.

Test Plan:
- Reset then idle, DATA_W=8, BAUD_DIV=4 → oTX=1, oBUSY=0, oDATA_READY=1 from the first edge after rst release; no strobes for 100 cycles.
- Single word 0xA5 with a behavioural LSB-first PISO model → oTX bits 0, 1,0,1,0,0,1,0,1, 1.
  - Each bit held 4 cycles; frame 40 cycles; one oLOAD, eight oSHIFT.
  - oDATA_READY high only on cycle 40 and in IDLE.
- Back-to-back 0x00 then 0xFF with iDATA_VALID held high → second START follows the first STOP with no idle cycle. Total 80 cycles; oTX=0x00 frame then 0xFF frame.
- iDATA_VALID pulsed during a frame and iDATA changed mid-frame → the pulse is not accepted and the transmitted word is unchanged.
- rst asserted in DATA bit 3 of 0x5A → oTX=1 and oBUSY=0 asynchronously, before the next edge. After release a new word 0x3C transmits correctly.
- SRLZR_PARITY_EN defined, words 0x07 and 0x03 → parity bit 1 then 0; frame 44 cycles each.

Source files
------------

// File: rtl/srlzr_tx_ctrl_if.sv
// Handshake and serializer-strobe bundle for srlzr_tx_ctrl.
// The controller connects through the slave modport; the word source/serializer side uses master.
interface srlzr_tx_ctrl_if #(
  parameter int unsigned DATA_W = 8
);
  logic [DATA_W-1:0] iDATA;
  logic              iDATA_VALID;
  logic              oDATA_READY;
  logic [DATA_W-1:0] oPAR_DATA;
  logic              oLOAD;
  logic              oSHIFT;
  logic              iSRL_IN;
  logic              oTX;
  logic              oBUSY;

  modport slave (
    input  iDATA, iDATA_VALID, iSRL_IN,
    output oDATA_READY, oPAR_DATA, oLOAD, oSHIFT, oTX, oBUSY
  );

  modport master (
    output iDATA, iDATA_VALID, iSRL_IN,
    input  oDATA_READY, oPAR_DATA, oLOAD, oSHIFT, oTX, oBUSY
  );
endinterface

// File: rtl/srlzr_tx_ctrl.sv
// Frame sequencer for the PISO serializer: start bit, DATA_W data bits, stop bit.
// Optional even-parity bit between data and stop when SRLZR_PARITY_EN is defined.
module srlzr_tx_ctrl #(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned BAUD_DIV = 4
) (
  input logic            clk,
  input logic            rst,
  srlzr_tx_ctrl_if.slave bus
);

  localparam int unsigned BAUD_W = $clog2(BAUD_DIV);
  localparam int unsigned BIT_W  = $clog2(DATA_W);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(BAUD_DIV - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_W - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
`ifdef SRLZR_PARITY_EN
    ST_PARITY,
`endif
    ST_STOP
  } state_t;

  state_t              r_state;
  logic [BAUD_W-1:0]   r_baud;
  logic [BIT_W-1:0]    r_bit;
  logic                r_ready;
  logic                r_load;
  logic                r_shift;
  logic                r_busy;
  logic                r_tx;
  logic [DATA_W-1:0]   r_par;

  state_t              w_state_nxt;
  logic [BAUD_W-1:0]   w_baud_nxt;
  logic [BIT_W-1:0]    w_bit_nxt;
  logic                w_baud_end;
  logic                w_accept;
  logic                w_line;

  // r_ready is only ever high in IDLE or on the last STOP cycle, so it alone qualifies a handshake.
  assign w_accept   = bus.iDATA_VALID & r_ready;
  assign w_baud_end = (r_baud == BAUD_LAST);

  always_comb begin
    w_state_nxt = r_state;
    w_baud_nxt  = r_baud;
    w_bit_nxt   = r_bit;
    unique case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_state_nxt = ST_START;
          w_baud_nxt  = '0;
        end
      end
      ST_START: begin
        if (w_baud_end) begin
          w_state_nxt = ST_DATA;
          w_baud_nxt  = '0;
          w_bit_nxt   = '0;
        end else begin
          w_baud_nxt  = r_baud + 1'b1;
        end
      end
      ST_DATA: begin
        if (w_baud_end) begin
          w_baud_nxt = '0;
          if (r_bit == BIT_LAST) begin
`ifdef SRLZR_PARITY_EN
            w_state_nxt = ST_PARITY;
`else
            w_state_nxt = ST_STOP;
`endif
          end else begin
            w_bit_nxt = r_bit + 1'b1;
          end
        end else begin
          w_baud_nxt = r_baud + 1'b1;
        end
      end
`ifdef SRLZR_PARITY_EN
      ST_PARITY: begin
        if (w_baud_end) begin
          w_state_nxt = ST_STOP;
          w_baud_nxt  = '0;
        end else begin
          w_baud_nxt  = r_baud + 1'b1;
        end
      end
`endif
      ST_STOP: begin
        if (w_baud_end) begin
          w_baud_nxt  = '0;
          w_state_nxt = w_accept ? ST_START : ST_IDLE;
        end else begin
          w_baud_nxt  = r_baud + 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_baud_nxt  = '0;
        w_bit_nxt   = '0;
      end
    endcase
  end

  // Line level of the current state; registering it delays oTX one cycle behind the
  // state, which lets the serializer's post-shift bit arrive in time for each bit period.
  always_comb begin
    w_line = 1'b1;
    unique case (r_state)
      ST_START:  w_line = 1'b0;
      ST_DATA:   w_line = bus.iSRL_IN;
`ifdef SRLZR_PARITY_EN
      ST_PARITY: w_line = ^r_par;
`endif
      default:   w_line = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_baud  <= '0;
      r_bit   <= '0;
      r_ready <= 1'b0;
      r_load  <= 1'b0;
      r_shift <= 1'b0;
      r_busy  <= 1'b0;
      r_tx    <= 1'b1;
      r_par   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_baud  <= w_baud_nxt;
      r_bit   <= w_bit_nxt;
      r_ready <= (w_state_nxt == ST_IDLE) ||
                 ((w_state_nxt == ST_STOP) && (w_baud_nxt == BAUD_LAST));
      r_load  <= (w_state_nxt == ST_START) && (w_baud_nxt == '0);
      r_shift <= (w_state_nxt == ST_DATA) && (w_baud_nxt == BAUD_LAST);
      r_busy  <= (w_state_nxt != ST_IDLE);
      r_tx    <= w_line;
      if (w_accept) begin
        r_par <= bus.iDATA;
      end
    end
  end

  assign bus.oDATA_READY = r_ready;
  assign bus.oPAR_DATA   = r_par;
  assign bus.oLOAD       = r_load;
  assign bus.oSHIFT      = r_shift;
  assign bus.oBUSY       = r_busy;
  assign bus.oTX         = r_tx;

endmodule

// File: tb/tb_srlzr_tx_ctrl.sv
// Directed bench for srlzr_tx_ctrl (DATA_W=8, BAUD_DIV=4) with a behavioural LSB-first PISO.
// Build with SRLZR_PARITY_EN defined to exercise the parity frame format.
module tb_srlzr_tx_ctrl;

  localparam int unsigned DATA_W   = 8;
  localparam int unsigned BAUD_DIV = 4;
`ifdef SRLZR_PARITY_EN
  localparam int unsigned PAR_BITS = 1;
`else
  localparam int unsigned PAR_BITS = 0;
`endif
  localparam int unsigned FRAME = (DATA_W + 2 + PAR_BITS) * BAUD_DIV;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  srlzr_tx_ctrl_if #(.DATA_W(DATA_W)) u_if ();

  srlzr_tx_ctrl #(
    .DATA_W   (DATA_W),
    .BAUD_DIV (BAUD_DIV)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (u_if.slave)
  );

  // External serializer: load on oLOAD, shift right on oSHIFT, bit 0 is the serial output.
  logic [DATA_W-1:0] r_sh;
  always_ff @(posedge clk or posedge rst) begin
    if (rst)              r_sh <= '0;
    else if (u_if.oLOAD)  r_sh <= u_if.oPAR_DATA;
    else if (u_if.oSHIFT) r_sh <= {1'b0, r_sh[DATA_W-1:1]};
  end
  assign u_if.iSRL_IN = r_sh[0];

  typedef struct {
    logic [7:0] word;
    logic [7:0] late_word;
    logic       b2b;
    logic       glitch;
    logic       par;
  } vec_t;

  vec_t tbl [6];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s[%0d]: got %0h, expected %0h", name, idx, act, exp);
    end
  endtask

  function automatic logic line_bit(input vec_t v, input int k);
    if (k == 0)                            return 1'b0;
    if (k <= 8)                            return v.word[k-1];
    if ((PAR_BITS == 1) && (k == 9))       return v.par;
    return 1'b1;
  endfunction

  function automatic logic [4:0] outs();
    return {u_if.oTX, u_if.oBUSY, u_if.oDATA_READY, u_if.oLOAD, u_if.oSHIFT};
  endfunction

  // Called at a negedge where the DUT is ready; returns at the negedge of the last frame cycle.
  task automatic do_frame(input vec_t v, input logic [7:0] next_word);
    logic [4:0] exp;
    u_if.iDATA       = v.word;
    u_if.iDATA_VALID = 1'b1;
    chk($sformatf("ready_at_accept_%0h", v.word), 0, u_if.oDATA_READY, 1);
    @(posedge clk);
    for (int j = 1; j <= int'(FRAME); j++) begin
      @(negedge clk);
      if (j == 1) begin
        if (v.b2b) u_if.iDATA = next_word;
        else begin
          u_if.iDATA_VALID = 1'b0;
          if (v.glitch) u_if.iDATA = v.late_word;
        end
      end
      if (v.glitch && j == 10) u_if.iDATA_VALID = 1'b1;
      if (v.glitch && j == 11) u_if.iDATA_VALID = 1'b0;
      exp[4] = (j == 1) ? 1'b1 : line_bit(v, (j - 2) / int'(BAUD_DIV));
      exp[3] = 1'b1;
      exp[2] = (j == int'(FRAME));
      exp[1] = (j == 1);
      exp[0] = (j > int'(BAUD_DIV)) && (j <= int'((DATA_W + 1) * BAUD_DIV)) &&
               (j % int'(BAUD_DIV) == 0);
      chk($sformatf("frame_%0h_tx_busy_rdy_ld_sh", v.word), j, outs(), exp);
    end
    chk($sformatf("par_data_%0h", v.word), 0, u_if.oPAR_DATA, v.word);
  endtask

  task automatic idle_check(input logic [7:0] tag);
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      chk($sformatf("post_idle_%0h", tag), j, outs(), 5'b10100);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    int strobes;
    int bad;
    vec_t v3c;

    tbl[0] = '{word: 8'hA5, late_word: 8'h00, b2b: 1'b0, glitch: 1'b0, par: 1'b0};
    tbl[1] = '{word: 8'h00, late_word: 8'h00, b2b: 1'b1, glitch: 1'b0, par: 1'b0};
    tbl[2] = '{word: 8'hFF, late_word: 8'h00, b2b: 1'b0, glitch: 1'b0, par: 1'b0};
    tbl[3] = '{word: 8'h96, late_word: 8'h69, b2b: 1'b0, glitch: 1'b1, par: 1'b0};
    tbl[4] = '{word: 8'h07, late_word: 8'h00, b2b: 1'b0, glitch: 1'b0, par: 1'b1};
    tbl[5] = '{word: 8'h03, late_word: 8'h00, b2b: 1'b0, glitch: 1'b0, par: 1'b0};
    v3c    = '{word: 8'h3C, late_word: 8'h00, b2b: 1'b0, glitch: 1'b0, par: 1'b0};

    rst              = 1'b1;
    u_if.iDATA       = '0;
    u_if.iDATA_VALID = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_outs", 0, outs(), 5'b10000);
    chk("reset_par_data", 0, u_if.oPAR_DATA, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("first_edge_idle", 0, outs(), 5'b10100);

    strobes = 0;
    bad     = 0;
    for (int j = 0; j < 100; j++) begin
      @(negedge clk);
      if (u_if.oLOAD || u_if.oSHIFT) strobes++;
      if (u_if.oTX !== 1'b1 || u_if.oBUSY !== 1'b0 || u_if.oDATA_READY !== 1'b1) bad++;
    end
    chk("idle_strobes", 0, strobes, 0);
    chk("idle_levels", 0, bad, 0);

    for (int i = 0; i < 6; i++) begin
      do_frame(tbl[i], (i < 5) ? tbl[i+1].word : 8'h00);
      if (!tbl[i].b2b) idle_check(tbl[i].word);
    end

    // Abort 0x5A while the state machine is in data bit 3 (line still showing bit 2 = 0).
    u_if.iDATA       = 8'h5A;
    u_if.iDATA_VALID = 1'b1;
    chk("ready_at_accept_5a", 0, u_if.oDATA_READY, 1);
    @(posedge clk);
    for (int j = 1; j <= 17; j++) begin
      @(negedge clk);
      if (j == 1) u_if.iDATA_VALID = 1'b0;
    end
    chk("pre_abort_tx_busy", 0, {u_if.oTX, u_if.oBUSY}, 2'b01);
    rst = 1'b1;
    #1;
    chk("async_abort_outs", 0, outs(), 5'b10000);
    repeat (2) @(negedge clk);
    chk("abort_held_outs", 0, outs(), 5'b10000);
    rst = 1'b0;
    @(negedge clk);
    chk("abort_release_idle", 0, outs(), 5'b10100);
    do_frame(v3c, 8'h00);
    idle_check(v3c.word);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
